// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: scans OAM during horizontal blanking for up to
// eight sprites that hit the next line, fetches their 2bpp row words from
// sprite graphics memory, and commits them to the slot outputs at hcount 0.
// Optional build macro: SPRITE_HFLIP_EN (mirror fetched rows of hflip sprites).
module sprite_line_scheduler #(
    parameter int unsigned NUM_SPRITES = 64,
    parameter int unsigned EVAL_START  = 640,
    parameter int unsigned V_TOTAL     = 525
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [10:0]  hcount,
    input  logic [9:0]   vcount,
    output logic [7:0]   oam_addr,
    input  logic [31:0]  oam_rdata,
    output logic [10:0]  sg_addr,
    input  logic [31:0]  sg_rdata,
    output logic [255:0] slot_gfx,
    output logic [79:0]  slot_x,
    output logic [7:0]   slot_palette,
    output logic [7:0]   slot_valid,
    output logic         load_sprite,
    output logic         busy,
    output logic         overflow,
    output logic         late
);

    localparam int unsigned SLOTS   = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned OAM_AW  = 8;
    localparam int unsigned SG_AW   = 11;
    localparam int unsigned GFX_W   = 32;
    localparam int unsigned X_W     = 10;
    localparam int unsigned Y_W     = 9;
    localparam int unsigned TILE_W  = 7;
    localparam int unsigned ROW_W   = 4;
    localparam int unsigned LINE_W  = 10;
    localparam int unsigned SPR_H   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_FETCH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e state_q, state_d;

    // OAM scan pipeline
    logic [OAM_AW-1:0] oam_addr_q, oam_addr_d;
    logic              cmp_vld_q, cmp_vld_d;
    logic              cmp_last_q, cmp_last_d;
    logic              issued_all_q, issued_all_d;
    logic [CNT_W-1:0]  found_q, found_d;

    // shadow (next-line) slot contents
    logic [SLOTS-1:0][TILE_W-1:0] sh_tile_q, sh_tile_d;
    logic [SLOTS-1:0][ROW_W-1:0]  sh_row_q, sh_row_d;
    logic [SLOTS-1:0][X_W-1:0]    sh_x_q, sh_x_d;
    logic [SLOTS-1:0][GFX_W-1:0]  sh_gfx_q, sh_gfx_d;
    logic [SLOTS-1:0]             sh_pal_q, sh_pal_d;
    logic [SLOTS-1:0]             sh_vld_q, sh_vld_d;
    logic                         sh_ovf_q, sh_ovf_d;
`ifdef SPRITE_HFLIP_EN
    logic [SLOTS-1:0]             sh_hflip_q, sh_hflip_d;
`endif

    // graphics fetch pipeline
    logic [SG_AW-1:0]  sg_addr_q, sg_addr_d;
    logic [CNT_W-1:0]  fi_q, fi_d;
    logic              sg_pend_q, sg_pend_d;
    logic [IDX_W-1:0]  pend_idx_q, pend_idx_d;
    logic              cap_vld_q, cap_vld_d;
    logic [IDX_W-1:0]  cap_idx_q, cap_idx_d;

    // committed outputs
    logic [SLOTS-1:0][GFX_W-1:0] slot_gfx_q, slot_gfx_d;
    logic [SLOTS-1:0][X_W-1:0]   slot_x_q, slot_x_d;
    logic [SLOTS-1:0]            slot_pal_q, slot_pal_d;
    logic [SLOTS-1:0]            slot_vld_q, slot_vld_d;
    logic                        load_q, load_d;
    logic                        busy_q, busy_d;
    logic                        ovf_q, ovf_d;
    logic                        late_q, late_d;

    // OAM entry decode
    logic [LINE_W-1:0] target_c;
    logic [LINE_W-1:0] dy_c;
    logic [X_W-1:0]    ent_x_c;
    logic [Y_W-1:0]    ent_y_c;
    logic [TILE_W-1:0] ent_tile_c;
    logic              ent_pal_c;
    logic              ent_en_c;
    logic              hit_c;
    logic              end_eval_c;
    logic [GFX_W-1:0]  cap_word_c;
    logic              unused_c;

`ifdef SPRITE_HFLIP_EN
    // Reverse the order of the sixteen 2-bit pixels in a row word.
    function automatic logic [GFX_W-1:0] pix_rev(input logic [GFX_W-1:0] w);
        logic [GFX_W-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[2*(15-i) +: 2] = w[2*i +: 2];
        end
        return r;
    endfunction
`endif

    // Target line, field extraction and range compare for the returned OAM word.
    always_comb begin
        target_c   = (vcount == LINE_W'(V_TOTAL - 1)) ? '0 : vcount + LINE_W'(1);
        ent_x_c    = oam_rdata[9:0];
        ent_y_c    = oam_rdata[18:10];
        ent_tile_c = oam_rdata[25:19];
        ent_pal_c  = oam_rdata[26];
        ent_en_c   = oam_rdata[27];
        dy_c       = target_c - {1'b0, ent_y_c};
        hit_c      = ent_en_c && (dy_c < LINE_W'(SPR_H));
`ifdef SPRITE_HFLIP_EN
        unused_c   = ^oam_rdata[31:29];
        cap_word_c = sh_hflip_q[cap_idx_q] ? pix_rev(sg_rdata) : sg_rdata;
`else
        unused_c   = ^oam_rdata[31:28];
        cap_word_c = sg_rdata;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and datapath next values; commit at hcount 0 overrides all.
    always_comb begin
        state_d      = state_q;
        oam_addr_d   = oam_addr_q;
        cmp_vld_d    = 1'b0;
        cmp_last_d   = cmp_last_q;
        issued_all_d = issued_all_q;
        found_d      = found_q;
        sh_tile_d    = sh_tile_q;
        sh_row_d     = sh_row_q;
        sh_x_d       = sh_x_q;
        sh_gfx_d     = sh_gfx_q;
        sh_pal_d     = sh_pal_q;
        sh_vld_d     = sh_vld_q;
        sh_ovf_d     = sh_ovf_q;
`ifdef SPRITE_HFLIP_EN
        sh_hflip_d   = sh_hflip_q;
`endif
        sg_addr_d    = sg_addr_q;
        fi_d         = fi_q;
        sg_pend_d    = 1'b0;
        pend_idx_d   = pend_idx_q;
        cap_vld_d    = 1'b0;
        cap_idx_d    = cap_idx_q;
        slot_gfx_d   = slot_gfx_q;
        slot_x_d     = slot_x_q;
        slot_pal_d   = slot_pal_q;
        slot_vld_d   = slot_vld_q;
        load_d       = 1'b0;
        ovf_d        = ovf_q;
        late_d       = late_q;
        end_eval_c   = 1'b0;

        if (hcount == '0) begin
            load_d  = 1'b1;
            state_d = ST_IDLE;
            case (state_q)
                ST_DONE: begin
                    slot_gfx_d = sh_gfx_q;
                    slot_x_d   = sh_x_q;
                    slot_pal_d = sh_pal_q;
                    slot_vld_d = sh_vld_q;
                    ovf_d      = sh_ovf_q;
                    late_d     = 1'b0;
                end
                ST_EVAL, ST_FETCH: begin
                    slot_vld_d = '0;
                    late_d     = 1'b1;
                end
                default: begin
                    slot_vld_d = '0;
                end
            endcase
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hcount == SG_AW'(EVAL_START)) begin
                        state_d      = ST_EVAL;
                        oam_addr_d   = '0;
                        issued_all_d = 1'b0;
                        cmp_last_d   = 1'b0;
                        found_d      = '0;
                        sh_tile_d    = '0;
                        sh_row_d     = '0;
                        sh_x_d       = '0;
                        sh_gfx_d     = '0;
                        sh_pal_d     = '0;
                        sh_vld_d     = '0;
                        sh_ovf_d     = 1'b0;
`ifdef SPRITE_HFLIP_EN
                        sh_hflip_d   = '0;
`endif
                    end
                end
                ST_EVAL: begin
                    // the address presented now returns data next cycle
                    if (!issued_all_q) begin
                        cmp_vld_d  = 1'b1;
                        cmp_last_d = (oam_addr_q == OAM_AW'(NUM_SPRITES - 1));
                        if (oam_addr_q == OAM_AW'(NUM_SPRITES - 1)) issued_all_d = 1'b1;
                        else oam_addr_d = oam_addr_q + OAM_AW'(1);
                    end
                    if (cmp_vld_q) begin
                        if (hit_c) begin
                            if (found_q == CNT_W'(SLOTS)) begin
                                sh_ovf_d   = 1'b1;
                                end_eval_c = 1'b1;
                            end else begin
                                sh_tile_d[found_q[IDX_W-1:0]] = ent_tile_c;
                                sh_row_d[found_q[IDX_W-1:0]]  = dy_c[ROW_W-1:0];
                                sh_x_d[found_q[IDX_W-1:0]]    = ent_x_c;
                                sh_pal_d[found_q[IDX_W-1:0]]  = ent_pal_c;
                                sh_vld_d[found_q[IDX_W-1:0]]  = 1'b1;
`ifdef SPRITE_HFLIP_EN
                                sh_hflip_d[found_q[IDX_W-1:0]] = oam_rdata[28];
`endif
                                found_d = found_q + CNT_W'(1);
                            end
                        end
                        if (cmp_last_q) end_eval_c = 1'b1;
                    end
                    if (end_eval_c) begin
                        cmp_vld_d = 1'b0;
                        fi_d      = '0;
                        state_d   = (found_d == '0) ? ST_DONE : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (fi_q < found_q) begin
                        sg_addr_d  = {sh_tile_q[fi_q[IDX_W-1:0]], sh_row_q[fi_q[IDX_W-1:0]]};
                        fi_d       = fi_q + CNT_W'(1);
                        sg_pend_d  = 1'b1;
                        pend_idx_d = fi_q[IDX_W-1:0];
                    end
                    if (sg_pend_q) begin
                        cap_vld_d = 1'b1;
                        cap_idx_d = pend_idx_q;
                    end
                    if (cap_vld_q) begin
                        sh_gfx_d[cap_idx_q] = cap_word_c;
                        if ({1'b0, cap_idx_q} == found_q - CNT_W'(1)) state_d = ST_DONE;
                    end
                end
                default: begin
                end
            endcase
        end

        busy_d = (state_d == ST_EVAL) || (state_d == ST_FETCH);
    end

    // Datapath and output registers; reset discards any shadow contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oam_addr_q   <= '0;
            cmp_vld_q    <= 1'b0;
            cmp_last_q   <= 1'b0;
            issued_all_q <= 1'b0;
            found_q      <= '0;
            sh_tile_q    <= '0;
            sh_row_q     <= '0;
            sh_x_q       <= '0;
            sh_gfx_q     <= '0;
            sh_pal_q     <= '0;
            sh_vld_q     <= '0;
            sh_ovf_q     <= 1'b0;
`ifdef SPRITE_HFLIP_EN
            sh_hflip_q   <= '0;
`endif
            sg_addr_q    <= '0;
            fi_q         <= '0;
            sg_pend_q    <= 1'b0;
            pend_idx_q   <= '0;
            cap_vld_q    <= 1'b0;
            cap_idx_q    <= '0;
            slot_gfx_q   <= '0;
            slot_x_q     <= '0;
            slot_pal_q   <= '0;
            slot_vld_q   <= '0;
            load_q       <= 1'b0;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
            late_q       <= 1'b0;
        end else begin
            oam_addr_q   <= oam_addr_d;
            cmp_vld_q    <= cmp_vld_d;
            cmp_last_q   <= cmp_last_d;
            issued_all_q <= issued_all_d;
            found_q      <= found_d;
            sh_tile_q    <= sh_tile_d;
            sh_row_q     <= sh_row_d;
            sh_x_q       <= sh_x_d;
            sh_gfx_q     <= sh_gfx_d;
            sh_pal_q     <= sh_pal_d;
            sh_vld_q     <= sh_vld_d;
            sh_ovf_q     <= sh_ovf_d;
`ifdef SPRITE_HFLIP_EN
            sh_hflip_q   <= sh_hflip_d;
`endif
            sg_addr_q    <= sg_addr_d;
            fi_q         <= fi_d;
            sg_pend_q    <= sg_pend_d;
            pend_idx_q   <= pend_idx_d;
            cap_vld_q    <= cap_vld_d;
            cap_idx_q    <= cap_idx_d;
            slot_gfx_q   <= slot_gfx_d;
            slot_x_q     <= slot_x_d;
            slot_pal_q   <= slot_pal_d;
            slot_vld_q   <= slot_vld_d;
            load_q       <= load_d;
            busy_q       <= busy_d;
            ovf_q        <= ovf_d;
            late_q       <= late_d;
        end
    end

    assign oam_addr     = oam_addr_q;
    assign sg_addr      = sg_addr_q;
    assign slot_gfx     = slot_gfx_q;
    assign slot_x       = slot_x_q;
    assign slot_palette = slot_pal_q;
    assign slot_valid   = slot_vld_q;
    assign load_sprite  = load_q;
    assign busy         = busy_q;
    assign overflow     = ovf_q;
    assign late         = late_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Bench for sprite_line_scheduler: directed scanlines with a registered OAM and
// graphics memory model; expected commits are queued and checked on load_sprite.
module tb_sprite_line_scheduler;

    logic         clk;
    logic         reset;
    logic [10:0]  hcount;
    logic [9:0]   vcount;
    logic [7:0]   oam_addr;
    logic [31:0]  oam_rdata;
    logic [10:0]  sg_addr;
    logic [31:0]  sg_rdata;
    logic [255:0] slot_gfx;
    logic [79:0]  slot_x;
    logic [7:0]   slot_palette;
    logic [7:0]   slot_valid;
    logic         load_sprite;
    logic         busy;
    logic         overflow;
    logic         late;

    typedef struct packed {
        logic [255:0] gfx;
        logic [79:0]  x;
        logic [7:0]   pal;
        logic [7:0]   vld;
        logic         ovf;
        logic         late;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [31:0] oam_mem [256];
    logic [10:0] ovr_addr;
    logic [31:0] ovr_data;

    sprite_line_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .hcount       (hcount),
        .vcount       (vcount),
        .oam_addr     (oam_addr),
        .oam_rdata    (oam_rdata),
        .sg_addr      (sg_addr),
        .sg_rdata     (sg_rdata),
        .slot_gfx     (slot_gfx),
        .slot_x       (slot_x),
        .slot_palette (slot_palette),
        .slot_valid   (slot_valid),
        .load_sprite  (load_sprite),
        .busy         (busy),
        .overflow     (overflow),
        .late         (late)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Graphics memory content: a fixed per-address pattern plus one override.
    function automatic logic [31:0] sg_word(input logic [10:0] a);
        if (a == ovr_addr) return ovr_data;
        return 32'h1357_0000 + 32'(a) * 32'd257;
    endfunction

    always @(posedge clk) begin
        oam_rdata <= oam_mem[oam_addr];
        sg_rdata  <= sg_word(sg_addr);
    end

    function automatic logic [31:0] oam_word(input int x, input int y, input int tile,
                                             input logic pal, input logic en, input logic hf);
        return {3'b000, hf, en, pal, 7'(tile), 9'(y), 10'(x)};
    endfunction

    function automatic exp_t add_slot(input exp_t e, input int k, input int x,
                                      input logic pal, input logic [31:0] g);
        exp_t r;
        r = e;
        r.gfx[32*k +: 32] = g;
        r.x[10*k +: 10]   = 10'(x);
        r.pal[k]          = pal;
        r.vld[k]          = 1'b1;
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every commit pulse is compared against the oldest expectation.
    always @(negedge clk) begin
        if (reset && load_sprite) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_load: got load_sprite=1 expected no commit");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("commit_gfx", slot_gfx, e.gfx);
                check("commit_x", 256'(slot_x), 256'(e.x));
                check("commit_palette", 256'(slot_palette), 256'(e.pal));
                check("commit_valid", 256'(slot_valid), 256'(e.vld));
                check("commit_overflow", 256'(overflow), 256'(e.ovf));
                check("commit_late", 256'(late), 256'(e.late));
            end
        end
    end

    task automatic clear_oam();
        for (int i = 0; i < 256; i++) oam_mem[i] = 32'h0;
    endtask

    // One blanking interval from start_h to stop_h, then the hcount 0 commit cycle.
    task automatic run_line(input int v, input int start_h, input int stop_h);
        vcount = 10'(v);
        for (int h = start_h; h <= stop_h; h++) begin
            hcount = 11'(h);
            @(posedge clk); #1;
        end
        hcount = 11'd0;
        @(posedge clk); #1;
        hcount = 11'd1;
        @(posedge clk); #1;
        hcount = 11'd2;
        check("load_single_cycle", 256'(load_sprite), 256'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        reset    = 1'b0;
        hcount   = 11'd1;
        vcount   = 10'd0;
        ovr_addr = 11'h7FF;
        ovr_data = 32'h0;
        clear_oam();
        repeat (3) @(posedge clk);
        #1;
        check("rst_oam_addr", 256'(oam_addr), 256'(0));
        check("rst_sg_addr", 256'(sg_addr), 256'(0));
        check("rst_slot_gfx", slot_gfx, 256'(0));
        check("rst_slot_valid", 256'(slot_valid), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_late", 256'(late), 256'(0));
        reset = 1'b1;
        @(posedge clk); #1;

        // commit with no evaluation started
        exp_q.push_back('0);
        run_line(0, 630, 0);

        // single sprite at OAM[5]: target 100, row 0, tile 3
        oam_mem[5] = oam_word(200, 100, 3, 1'b0, 1'b1, 1'b0);
        e = add_slot('0, 0, 200, 1'b0, sg_word(11'd48));
        exp_q.push_back(e);
        run_line(99, 630, 799);
        check("single_sg_addr", 256'(sg_addr), 256'(48));
        check("single_idle_busy", 256'(busy), 256'(0));

        // late commit: evaluation aborted, previous slot data kept, valid cleared
        e.vld  = '0;
        e.late = 1'b1;
        exp_q.push_back(e);
        run_line(99, 630, 650);

        // nine sprites on one line: first eight kept, overflow set
        clear_oam();
        for (int i = 0; i < 9; i++) oam_mem[i] = oam_word(10*i + 3, 50, i + 1, 1'(i), 1'b1, 1'b0);
        e = '0;
        for (int k = 0; k < 8; k++) e = add_slot(e, k, 10*k + 3, 1'(k), sg_word(11'((k + 1) * 16 + 1)));
        e.ovf = 1'b1;
        exp_q.push_back(e);
        run_line(50, 630, 799);

        // asynchronous reset during the graphics fetch
        vcount = 10'd50;
        for (int h = 630; h <= 653; h++) begin
            hcount = 11'(h);
            @(posedge clk); #1;
        end
        check("midfetch_busy", 256'(busy), 256'(1));
        reset = 1'b0;
        #1;
        check("rst_mid_oam_addr", 256'(oam_addr), 256'(0));
        check("rst_mid_sg_addr", 256'(sg_addr), 256'(0));
        check("rst_mid_slot_gfx", slot_gfx, 256'(0));
        check("rst_mid_slot_x", 256'(slot_x), 256'(0));
        check("rst_mid_palette", 256'(slot_palette), 256'(0));
        check("rst_mid_valid", 256'(slot_valid), 256'(0));
        check("rst_mid_busy", 256'(busy), 256'(0));
        check("rst_mid_overflow", 256'(overflow), 256'(0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // wrap: vcount 524 targets line 0; y=0 hits, y=1 misses
        clear_oam();
        oam_mem[0] = oam_word(5, 0, 7, 1'b0, 1'b1, 1'b0);
        oam_mem[1] = oam_word(6, 1, 2, 1'b0, 1'b1, 1'b0);
        oam_mem[2] = oam_word(9, 2, 4, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(add_slot('0, 0, 5, 1'b0, sg_word(11'd112)));
        run_line(524, 630, 799);

        // target 17: y=1 is row 16 (miss), y=2 is row 15 (hit)
        exp_q.push_back(add_slot('0, 0, 9, 1'b0, sg_word(11'd79)));
        run_line(16, 630, 799);

        // disabled sprite in range is ignored
        clear_oam();
        oam_mem[3] = oam_word(50, 100, 5, 1'b1, 1'b0, 1'b0);
        exp_q.push_back('0);
        run_line(99, 630, 799);

        // hflip sprite with a single pixel in the lowest position
        clear_oam();
        oam_mem[0] = oam_word(300, 100, 9, 1'b1, 1'b1, 1'b1);
        ovr_addr   = 11'd144;
        ovr_data   = 32'h0000_0001;
`ifdef SPRITE_HFLIP_EN
        exp_q.push_back(add_slot('0, 0, 300, 1'b1, 32'h4000_0000));
`else
        exp_q.push_back(add_slot('0, 0, 300, 1'b1, 32'h0000_0001));
`endif
        run_line(99, 630, 799);

        repeat (4) @(posedge clk);
        #1;
        check("pending_commits", 256'(exp_q.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
